// File: rtl/alu_driver.sv
// Request-side sequencer for the 2-bit-command datapath ALU.
// Runs one or more ALU passes per request and returns the result on a response channel.
module alu_driver #(
  parameter int           W      = 8,
  parameter logic [W-1:0] IDLE_B = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_eq,
  output logic         resp_pari,
  output logic         resp_err,
  output logic [1:0]   alu_cmd,
  output logic [W-1:0] alu_inA,
  output logic [W-1:0] alu_inB,
  input  logic [W-1:0] alu_rslt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ROR  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  localparam logic [1:0] C_ADD  = 2'b00;
  localparam logic [1:0] C_ROR  = 2'b01;
  localparam logic [1:0] C_NAND = 2'b10;
  localparam logic [1:0] C_PASS = 2'b11;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       r_state;
  state_t       w_next;
  logic [2:0]   r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_tmp;
  logic [1:0]   r_step;
  logic         r_eq_lat;
  logic [W-1:0] r_data;
  logic         r_eq;
  logic         r_pari;
  logic         r_err;
  logic         w_last;
  logic         w_acc;
  logic [1:0]   w_cmd;
  logic [W-1:0] w_inA;
  logic [W-1:0] w_inB;

  assign w_acc  = req_valid && (r_state == S_IDLE);
  assign w_last = (r_op != OP_SUB) || (r_step == 2'd2);

  always_comb begin
    w_next = r_state;
    w_cmd  = C_PASS;
    w_inA  = IDLE_B;
    w_inB  = IDLE_B;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid)
          w_next = (req_op == OP_RSV) ? S_RESP : S_EXEC;
      end
      S_EXEC: begin
        w_inA = r_a;
        w_inB = r_b;
        case (r_op)
          OP_ADD:  w_cmd = C_ADD;
          OP_ROR:  w_cmd = C_ROR;
          OP_NAND: w_cmd = C_NAND;
          OP_PASS: w_cmd = C_PASS;
          OP_NOT: begin
            w_cmd = C_NAND;
            w_inB = r_a;
          end
          OP_INC: begin
            w_cmd = C_ADD;
            w_inB = ONE;
          end
          OP_SUB: begin
            // ~b, then a + ~b, then + 1
            case (r_step)
              2'd0: begin
                w_cmd = C_NAND;
                w_inA = r_b;
              end
              2'd1: begin
                w_cmd = C_ADD;
                w_inB = r_tmp;
              end
              default: begin
                w_cmd = C_ADD;
                w_inA = r_tmp;
                w_inB = ONE;
              end
            endcase
          end
          default: w_cmd = C_PASS;
        endcase
        if (w_last)
          w_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_tmp    <= '0;
      r_step   <= '0;
      r_eq_lat <= 1'b0;
      r_data   <= '0;
      r_eq     <= 1'b0;
      r_pari   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_op     <= req_op;
        r_a      <= req_a;
        r_b      <= req_b;
        r_step   <= '0;
        r_eq_lat <= (req_a == req_b);
        if (req_op == OP_RSV) begin
          r_data <= '0;
          r_pari <= 1'b0;
          r_err  <= 1'b1;
          r_eq   <= (req_a == req_b);
        end
      end
      if (r_state == S_EXEC) begin
        r_tmp  <= alu_rslt;
        r_step <= r_step + 2'd1;
        if (w_last) begin
          r_data <= alu_rslt;
          r_pari <= ^alu_rslt;
          r_err  <= 1'b0;
          r_eq   <= r_eq_lat;
        end
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_data;
  assign resp_eq    = r_eq;
  assign resp_pari  = r_pari;
  assign resp_err   = r_err;
  assign alu_cmd    = w_cmd;
  assign alu_inA    = w_inA;
  assign alu_inB    = w_inB;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: behavioural ALU, reference model and response scoreboard.
// Covers latency, SUB pass sequence, wrap cases, backpressure, reserved op and mid-op reset.
module tb_alu_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic         resp_eq;
  logic         resp_pari;
  logic         resp_err;
  logic [1:0]   alu_cmd;
  logic [W-1:0] alu_inA;
  logic [W-1:0] alu_inB;
  logic [W-1:0] alu_rslt;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         eq;
    logic         pari;
    logic         err;
  } exp_t;

  exp_t sb[$];

  alu_driver #(.W(W), .IDLE_B('0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_eq    (resp_eq),
    .resp_pari  (resp_pari),
    .resp_err   (resp_err),
    .alu_cmd    (alu_cmd),
    .alu_inA    (alu_inA),
    .alu_inB    (alu_inB),
    .alu_rslt   (alu_rslt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: rotate amount is B mod W
  always_comb begin
    logic [2:0] s;
    s = alu_inB[2:0];
    alu_rslt = '0;
    case (alu_cmd)
      2'b00: alu_rslt = alu_inA + alu_inB;
      2'b01: alu_rslt = (alu_inA >> s) | (alu_inA << (4'd8 - {1'b0, s}));
      2'b10: alu_rslt = ~(alu_inA & alu_inB);
      default: alu_rslt = alu_inB;
    endcase
  end

  function automatic exp_t ref_model(logic [2:0] op, logic [W-1:0] a,
                                     logic [W-1:0] b);
    exp_t e;
    logic [15:0] r2;
    r2 = {a, a} >> b[2:0];
    e.err = 1'b0;
    case (op)
      3'd0: e.d = a + b;
      3'd1: e.d = r2[7:0];
      3'd2: e.d = ~(a & b);
      3'd3: e.d = b;
      3'd4: e.d = a - b;
      3'd5: e.d = ~a;
      3'd6: e.d = a + 8'd1;
      default: begin
        e.d   = 8'h00;
        e.err = 1'b1;
      end
    endcase
    e.eq   = (a == b);
    e.pari = ^e.d;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                     int hold);
    int         lat;
    int         ncmd;
    int         exp_lat;
    logic [1:0] cmds[8];
    logic [W-1:0] snap;
    exp_t       e;
    exp_lat = (op == 3'd4) ? 4 : (op == 3'd7) ? 1 : 2;
    chk("req_ready_pre", {31'd0, req_ready}, 32'd1);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    sb.push_back(ref_model(op, a, b));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = W'($urandom);
    req_b     = W'($urandom);
    req_op    = 3'($urandom);
    lat  = 1;
    ncmd = 0;
    while (!resp_valid && lat < 20) begin
      if (ncmd < 8) cmds[ncmd] = alu_cmd;
      ncmd++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (op == 3'd4) begin
      chk("sub_npass", ncmd, 3);
      chk("sub_cmd0", {30'd0, cmds[0]}, 32'd2);
      chk("sub_cmd1", {30'd0, cmds[1]}, 32'd0);
      chk("sub_cmd2", {30'd0, cmds[2]}, 32'd0);
    end
    if (op == 3'd7)
      chk("rsv_cmd", {30'd0, alu_cmd}, 32'd3);
    snap = resp_data;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_op    = 3'd0;
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_data", {24'd0, resp_data}, {24'd0, snap});
    end
    req_valid = 1'b0;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("data", {24'd0, resp_data}, {24'd0, e.d});
      chk("eq", {31'd0, resp_eq}, {31'd0, e.eq});
      chk("pari", {31'd0, resp_pari}, {31'd0, e.pari});
      chk("err", {31'd0, resp_err}, {31'd0, e.err});
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      chk("post_valid", {31'd0, resp_valid}, 32'd0);
      chk("post_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_hold", {24'd0, resp_data}, {24'd0, e.d});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", {24'd0, resp_data}, 32'd0);
    chk("rst_flags", {29'd0, resp_eq, resp_pari, resp_err}, 32'd0);
    chk("rst_cmd", {30'd0, alu_cmd}, 32'd3);
    chk("rst_inA", {24'd0, alu_inA}, 32'd0);
    chk("rst_inB", {24'd0, alu_inB}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(3'd0, 8'h7F, 8'h01, 0);
    run(3'd4, 8'h05, 8'h07, 0);
    run(3'd0, 8'hFF, 8'h01, 0);
    run(3'd6, 8'hFF, 8'h00, 0);
    run(3'd2, 8'hF0, 8'h3C, 0);
    run(3'd3, 8'h3C, 8'h3C, 0);
    run(3'd1, 8'h81, 8'h03, 0);
    run(3'd5, 8'hA5, 8'h11, 0);
    run(3'd0, 8'h12, 8'h34, 5);
    run(3'd7, 8'h55, 8'h55, 0);
    run(3'd4, 8'h00, 8'h01, 2);

    for (int k = 0; k < 24; k++)
      run(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), k % 3);

    // Reset during SUB step 1
    req_op    = 3'd4;
    req_a     = 8'h05;
    req_b     = 8'h07;
    req_valid = 1'b1;
    sb.push_back(ref_model(3'd4, 8'h05, 8'h07));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_step1_cmd", {30'd0, alu_cmd}, 32'd0);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("mr_ready", {31'd0, req_ready}, 32'd1);
    chk("mr_valid", {31'd0, resp_valid}, 32'd0);
    chk("mr_cmd", {30'd0, alu_cmd}, 32'd3);
    chk("mr_inA", {24'd0, alu_inA}, 32'd0);
    chk("mr_inB", {24'd0, alu_inB}, 32'd0);
    chk("mr_data", {24'd0, resp_data}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mr_noresp", {31'd0, resp_valid}, 32'd0);
    end
    run(3'd0, 8'h02, 8'h03, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
